// File: rtl/bam_sched_pkg.sv
// Shared defaults and types for the shared approximate multiplier scheduler.
// Broken-array multiplier cut helper and S2 payload layout.
package bam_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int DEF_HCUT = 5;
    localparam int DEF_VCUT = 8;
    localparam int DEF_TW   = $clog2(DEF_NREQ);

    typedef struct packed {
        logic [DEF_TW-1:0]  tag;
        logic [2*DEF_W-1:0] prod;
    } s2_pay_t;

    // Partial product a[i]&b[j] survives both the row and diagonal breaks.
    function automatic logic pp_keep(
        input int i,
        input int j,
        input int hcut,
        input int vcut
    );
        return (j >= hcut) && (i + j >= vcut);
    endfunction

endpackage

// File: rtl/bam_pp_core.sv
// Combinational broken-array multiplier core.
// Kept partial products are summed exactly into a full 2W-bit result.
module bam_pp_core
    import bam_sched_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int HCUT = DEF_HCUT,
    parameter int VCUT = DEF_VCUT
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod
);

    logic [2*W-1:0] rows [W];

    // Build one shifted partial-product row per multiplier bit.
    always_comb begin
        for (int j = 0; j < W; j++) begin
            rows[j] = '0;
            for (int i = 0; i < W; i++) begin
                rows[j][i+j] = a[i] & b[j]
                             & pp_keep(i, j, HCUT, VCUT);
            end
        end
    end

    // Add the surviving rows.
    always_comb begin
        prod = '0;
        for (int j = 0; j < W; j++) begin
            prod = prod + rows[j];
        end
    end

endmodule

// File: rtl/bam_mul_sched.sv
// Round-robin front end sharing one approximate multiplier among lanes.
// Two elastic register stages wrap the combinational core.
module bam_mul_sched
    import bam_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int HCUT = DEF_HCUT,
    parameter int VCUT = DEF_VCUT,
    parameter int TW   = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [TW-1:0]   resp_tag,
    output logic [2*W-1:0]  resp_prod,
    output logic [1:0]      inflight
);

    typedef struct packed {
        logic [TW-1:0]  tag;
        logic [2*W-1:0] prod;
    } s2_t;

    logic [TW-1:0]   rr;
    logic [NREQ-1:0] grant;
    logic [TW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [TW:0]     scan;

    logic            s1_v;
    logic [W-1:0]    s1_a;
    logic [W-1:0]    s1_b;
    logic [TW-1:0]   s1_tag;

    logic            s2_v;
    s2_t             s2_q;

    logic            s1_can_load;
    logic            s2_can_load;
    logic            xfer;
    logic [2*W-1:0]  core_prod;

    assign s2_can_load = !s2_v || resp_ready;
    assign s1_can_load = !s1_v || s2_can_load;
    assign req_ready   = grant & {NREQ{s1_can_load & !rst}};
    assign xfer        = gnt_any && s1_can_load;

    assign resp_valid = s2_v;
    assign resp_tag   = s2_q.tag;
    assign resp_prod  = s2_q.prod;
    assign inflight   = {1'b0, s1_v} + {1'b0, s2_v};

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        scan    = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan = {1'b0, rr} + (TW+1)'(off);
            if (scan >= (TW+1)'(NREQ)) begin
                scan = scan - (TW+1)'(NREQ);
            end
            if (!gnt_any && req_valid[scan[TW-1:0]]) begin
                gnt_any                = 1'b1;
                gnt_idx                = scan[TW-1:0];
                grant[scan[TW-1:0]]    = 1'b1;
            end
        end
    end

    // Advance the pointer past the requester that just transferred.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (xfer) begin
            rr <= (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Operand stage: capture the granted pair when it can move in.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
        end else if (s1_can_load) begin
            s1_v <= xfer;
            if (xfer) begin
                s1_a   <= req_a[gnt_idx*W +: W];
                s1_b   <= req_b[gnt_idx*W +: W];
                s1_tag <= gnt_idx;
            end
        end
    end

    bam_pp_core #(
        .W    (W),
        .HCUT (HCUT),
        .VCUT (VCUT)
    ) u_core (
        .a    (s1_a),
        .b    (s1_b),
        .prod (core_prod)
    );

    // Result stage: holds the product until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (s2_can_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_q <= '{tag: s1_tag, prod: core_prod};
            end
        end
    end

endmodule

// File: tb/tb_bam_mul_sched.sv
// Self-checking bench for the shared approximate multiplier scheduler.
// A queue-based reference tracks accepts and results every cycle.
module tb_bam_mul_sched;
    import bam_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_tag;
    logic [15:0]    resp_prod;
    logic [1:0]     inflight;

    logic [N-1:0]   x_valid;
    logic [N-1:0]   x_ready;
    logic [N*W-1:0] x_a;
    logic [N*W-1:0] x_b;
    logic           x_rvalid;
    logic           x_rready;
    logic [1:0]     x_tag;
    logic [15:0]    x_prod;
    logic [1:0]     x_infl;

    bam_mul_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_tag   (resp_tag),
        .resp_prod  (resp_prod),
        .inflight   (inflight)
    );

    bam_mul_sched #(.HCUT(0), .VCUT(0)) dut_x (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (x_valid),
        .req_ready  (x_ready),
        .req_a      (x_a),
        .req_b      (x_b),
        .resp_valid (x_rvalid),
        .resp_ready (x_rready),
        .resp_tag   (x_tag),
        .resp_prod  (x_prod),
        .inflight   (x_infl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        s2_pay_t pay;
        bit      s2;
    } mi_t;

    int       checks;
    int       errors;
    mi_t      q[$];
    int       m_rr;
    bit       started;
    int       waitc[N];
    logic [N-1:0] last_xfer;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Sum over kept rows: each set b[j] adds a (low bits below the
    // diagonal break cleared) shifted by j.
    function automatic int bam_ref(int a, int b, int hc, int vc);
        int p;
        int lo;
        p = 0;
        for (int j = hc; j < W; j++) begin
            if (((b >> j) & 1) == 1) begin
                lo = (vc - j < 0) ? 0 : vc - j;
                p += ((a >> lo) << lo) << j;
            end
        end
        return p & 16'hffff;
    endfunction

    // Sample at the falling edge: check outputs, then advance the model
    // for the coming rising edge using the inputs held right now.
    task automatic half();
        bit s1_full;
        bit s2_full;
        bit s1_free;
        int g;
        int mx;
        logic [N-1:0] exp_rdy;
        mi_t it;
        @(negedge clk);
        last_xfer = req_valid & req_ready;
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 0);
            q.delete();
            m_rr    = 0;
            started = 1;
            for (int k = 0; k < N; k++) waitc[k] = 0;
            return;
        end
        if (!started) return;
        s2_full = (q.size() > 0) && q[0].s2;
        s1_full = (q.size() == 2) || (q.size() == 1 && !q[0].s2);
        s1_free = !s1_full || !s2_full || resp_ready;
        chk("m_rvalid", 32'(resp_valid), 32'(s2_full));
        chk("m_infl", 32'(inflight), 32'(q.size()));
        if (s2_full) begin
            chk("m_tag", 32'(resp_tag), 32'(q[0].pay.tag));
            chk("m_prod", 32'(resp_prod), 32'(q[0].pay.prod));
        end
        g = -1;
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_rr + o) % N;
            if (g < 0 && req_valid[k]) g = k;
        end
        exp_rdy = (g >= 0 && s1_free) ? N'(1 << g) : '0;
        chk("m_ready", 32'(req_ready), 32'(exp_rdy));
        if (s2_full && resp_ready) void'(q.pop_front());
        if (q.size() == 1 && !q[0].s2) begin
            it = q[0];
            it.s2 = 1;
            q[0] = it;
        end
        if (exp_rdy != 0) begin
            it.pay.tag  = 2'(g);
            it.pay.prod = 16'(bam_ref(int'(req_a[g*W +: W]),
                                      int'(req_b[g*W +: W]), 5, 8));
            it.s2 = 0;
            q.push_back(it);
            m_rr = (g + 1) % N;
            mx = 0;
            for (int k = 0; k < N; k++) begin
                if (k == g || !req_valid[k]) waitc[k] = 0;
                else waitc[k]++;
                if (waitc[k] > mx) mx = waitc[k];
            end
            chk("starve", 32'(mx > N - 1), 0);
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) waitc[k] = 0;
            end
        end
    endtask

    // Rising edge; requesters that transferred drop their request.
    task automatic edge_();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_xfer;
    endtask

    task automatic send_one(int k, int a, int b, int ep, string nm);
        int n;
        req_a[k*W +: W] = W'(a);
        req_b[k*W +: W] = W'(b);
        req_valid  = N'(1 << k);
        resp_ready = 1'b1;
        n = 0;
        half();
        while (!req_ready[k] && n < 20) begin
            edge_();
            half();
            n++;
        end
        chk({nm, "_acc"}, 32'(req_ready[k]), 1);
        edge_();
        half();
        chk({nm, "_early"}, 32'(resp_valid), 0);
        edge_();
        half();
        chk({nm, "_rv"}, 32'(resp_valid), 1);
        chk({nm, "_tag"}, 32'(resp_tag), 32'(k));
        chk({nm, "_prod"}, 32'(resp_prod), 32'(ep));
        edge_();
        half();
        chk({nm, "_gone"}, 32'(resp_valid), 0);
        edge_();
    endtask

    initial begin
        logic [15:0] held;
        int tags[$];
        int n;
        checks = 0;
        errors = 0;
        started = 0;
        m_rr = 0;
        last_xfer = '0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        x_valid = '0;
        x_a = '0;
        x_b = '0;
        x_rready = 1'b1;

        chk("ref_ff", 32'(bam_ref(255, 255, 5, 8)), 56576);
        chk("ref_exact", 32'(bam_ref(255, 255, 0, 0)), 65025);
        chk("ref_b128", 32'(bam_ref(255, 128, 5, 8)), 32512);

        #1;
        half();
        edge_();
        half();
        chk("rst_rvalid", 32'(resp_valid), 0);
        chk("rst_infl", 32'(inflight), 0);
        chk("rst_tag", 32'(resp_tag), 0);
        chk("rst_prod", 32'(resp_prod), 0);
        edge_();
        rst = 1'b0;

        // exact-mode instance, requester 2
        x_valid = 4'b0100;
        x_a[2*W +: W] = 8'd255;
        x_b[2*W +: W] = 8'd255;
        half();
        chk("x_ready", 32'(x_ready), 32'h4);
        edge_();
        x_valid = '0;
        half();
        chk("x_early", 32'(x_rvalid), 0);
        edge_();
        half();
        chk("x_rv", 32'(x_rvalid), 1);
        chk("x_tag", 32'(x_tag), 2);
        chk("x_prod", 32'(x_prod), 65025);
        edge_();

        // default cuts
        send_one(1, 255, 255, 56576, "c_ff");
        send_one(3, 255, 128, 32512, "c_80");
        send_one(0, 1, 1, 0, "c_11");
        send_one(2, 15, 31, 0, "c_f1f");

        // fairness from a fresh pointer
        rst = 1'b1;
        half();
        edge_();
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = W'($urandom);
            req_b[k*W +: W] = W'($urandom);
        end
        req_valid = '1;
        resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            half();
            if (c < 8) chk("fair_rdy", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk("fair_rv", 32'(resp_valid), 1);
                chk("fair_tag", 32'(resp_tag), 32'((c - 2) % 4));
            end
            edge_();
            req_valid = '1;
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            half();
            edge_();
        end

        // backpressure with three pending requests
        rst = 1'b1;
        half();
        edge_();
        rst = 1'b0;
        resp_ready = 1'b0;
        req_valid = 4'b0111;
        half();
        edge_();
        half();
        edge_();
        held = 16'(bam_ref(int'(req_a[7:0]), int'(req_b[7:0]), 5, 8));
        for (int c = 0; c < 5; c++) begin
            half();
            chk("bp_infl", 32'(inflight), 2);
            chk("bp_rdy", 32'(req_ready), 0);
            chk("bp_rv", 32'(resp_valid), 1);
            chk("bp_tag", 32'(resp_tag), 0);
            chk("bp_prod", 32'(resp_prod), 32'(held));
            edge_();
        end
        resp_ready = 1'b1;
        tags.delete();
        for (int c = 0; c < 8; c++) begin
            half();
            if (resp_valid) tags.push_back(int'(resp_tag));
            edge_();
        end
        chk("bp_cnt", 32'(tags.size()), 3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_order", (i < tags.size()) ? 32'(tags[i]) : 32'hffff,
                32'(i));
        end

        // reset with both stages full
        resp_ready = 1'b0;
        req_valid = 4'b1010;
        half();
        edge_();
        half();
        edge_();
        half();
        chk("mr_infl", 32'(inflight), 2);
        edge_();
        rst = 1'b1;
        half();
        edge_();
        rst = 1'b0;
        req_valid = 4'b1011;
        resp_ready = 1'b1;
        half();
        chk("mr_infl0", 32'(inflight), 0);
        chk("mr_rv", 32'(resp_valid), 0);
        chk("mr_rdy", 32'(req_ready), 32'h1);
        edge_();
        tags.delete();
        for (int c = 0; c < 6; c++) begin
            half();
            if (resp_valid) tags.push_back(int'(resp_tag));
            edge_();
        end
        chk("mr_first", (tags.size() > 0) ? 32'(tags[0]) : 32'hffff, 0);
        req_valid = '0;

        // random soak
        n = 0;
        for (int c = 0; c < 3000; c++) begin
            half();
            edge_();
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) begin
                    if ($urandom_range(0, 9) < 4) begin
                        req_valid[k] = 1'b1;
                        req_a[k*W +: W] = W'($urandom);
                        req_b[k*W +: W] = W'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[k] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 9) < 7);
        end
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            half();
            edge_();
        end
        chk("drain", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
